// File: rtl/cacheline_arbiter.sv
// Two-way arbiter sharing one cacheline adaptor between the I-cache and the D-cache.
// Optional macro CACHELINE_ARB_RR_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
module cacheline_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] cla_addr,
  output logic              cla_read,
  output logic              cla_write,
  output logic [LINE_W-1:0] cla_wdata,
  input  logic [LINE_W-1:0] cla_rdata,
  input  logic              cla_resp,
  output logic              arb_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TURN} state_e;
  typedef enum logic {OWNER_I, OWNER_D} owner_e;

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

  logic i_req, d_req, tie_to_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef CACHELINE_ARB_RR_EN
  assign tie_to_d = (last_owner_q == OWNER_I);
`else
  assign tie_to_d = 1'b1;
`endif

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = tie_to_d ? GRANT_D : GRANT_I;
        else if (d_req)     state_d = GRANT_D;
        else if (i_req)     state_d = GRANT_I;
        if (i_req || d_req) cnt_d = '0;
      end
      GRANT_I, GRANT_D: begin
        if (cla_resp) begin
          state_d      = TURN;
          last_owner_d = (state_q == GRANT_I) ? OWNER_I : OWNER_D;
        end else if (cnt_q != TIMEOUT_CNT) begin
          // Saturates at TIMEOUT; the grant itself is never aborted.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_CNT) timeout_d = 1'b1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adaptor commands follow the live inputs of whichever side holds the grant.
  always_comb begin
    cla_addr  = '0;
    cla_read  = 1'b0;
    cla_write = 1'b0;
    cla_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      GRANT_I: begin
        cla_addr = i_addr;
        cla_read = i_read;
        i_resp   = cla_resp;
      end
      GRANT_D: begin
        cla_addr  = d_addr;
        cla_read  = d_read;
        cla_write = d_write & ~d_read;
        cla_wdata = d_wdata;
        d_resp    = cla_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata     = i_resp ? cla_rdata : i_rdata_q;
  assign d_rdata     = d_resp ? cla_rdata : d_rdata_q;
  assign arb_timeout = timeout_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      // NOTE: the line holders are reset because both rdata ports must read 0 after reset.
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      if (i_resp) i_rdata_q <= cla_rdata;
      if (d_resp) d_rdata_q <= cla_rdata;
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of grant ownership.
module tb_cacheline_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 1023;
  localparam logic [AW-1:0] I_ADDR_T4 = 32'h1000_0080;
  localparam logic [AW-1:0] D_ADDR_T4 = 32'h2000_0040;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr, d_addr, cla_addr;
  logic          i_read, i_resp, d_read, d_write, d_resp;
  logic          cla_read, cla_write, cla_resp, arb_timeout;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, cla_wdata, cla_rdata;

  always #5 clk = ~clk;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .cla_addr(cla_addr), .cla_read(cla_read), .cla_write(cla_write),
    .cla_wdata(cla_wdata), .cla_rdata(cla_rdata), .cla_resp(cla_resp),
    .arb_timeout(arb_timeout)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the adaptor, whether the post-completion gap is running,
  // how long the current grant has waited, and the last line each cache received.
  typedef enum logic [1:0] {NONE, I_SIDE, D_SIDE} side_e;
  side_e         m_owner, m_last;
  bit            m_gap;
  int            m_age;
  bit            m_tflag;
  logic [LW-1:0] m_i_line, m_d_line;
  int            m_i_done, m_d_done;

  bit  ad_busy, stray_en, prev_act;
  int  ad_wait, lat_lo, lat_hi, i_seen, d_seen;
  byte grants[$];
  string exp_order;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return $urandom & 32'hFFFF_FFE0;
  endfunction

  task automatic model_reset();
    m_owner = NONE; m_last = I_SIDE; m_gap = 0; m_age = 0; m_tflag = 0;
    m_i_line = '0; m_d_line = '0; m_i_done = 0; m_d_done = 0;
    ad_busy = 0; ad_wait = 0; i_seen = 0; d_seen = 0; prev_act = 0;
  endtask

  task automatic check_outputs();
    logic [AW-1:0] e_addr;
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [LW-1:0] e_wd;
    e_addr = '0; e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_wd = '0;
    case (m_owner)
      I_SIDE: begin e_addr = i_addr; e_rd = i_read; e_ir = cla_resp; end
      D_SIDE: begin
        e_addr = d_addr; e_rd = d_read; e_wr = d_write & ~d_read;
        e_wd = d_wdata; e_dr = cla_resp;
      end
      default: ;
    endcase
    check("cla_addr", cla_addr, e_addr);
    check("cla_read", cla_read, e_rd);
    check("cla_write", cla_write, e_wr);
    check("cla_wdata", cla_wdata, e_wd);
    check("i_resp", i_resp, e_ir);
    check("d_resp", d_resp, e_dr);
    check("i_rdata", i_rdata, e_ir ? cla_rdata : m_i_line);
    check("d_rdata", d_rdata, e_dr ? cla_rdata : m_d_line);
    check("arb_timeout", arb_timeout, m_tflag);
  endtask

  task automatic model_advance();
    bit iw, dw;
    if (m_owner != NONE) begin
      if (cla_resp) begin
        if (m_owner == I_SIDE) begin m_i_line = cla_rdata; m_i_done++; end
        else begin m_d_line = cla_rdata; m_d_done++; end
        m_last = m_owner; m_owner = NONE; m_gap = 1;
      end else if (m_age < TO) begin
        m_age++;
        if (m_age == TO) m_tflag = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      iw = i_read;
      dw = d_read | d_write;
      if (iw && dw) begin
`ifdef CACHELINE_ARB_RR_EN
        m_owner = (m_last == I_SIDE) ? D_SIDE : I_SIDE;
`else
        m_owner = D_SIDE;
`endif
      end else if (dw) m_owner = D_SIDE;
      else if (iw)     m_owner = I_SIDE;
      m_age = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
    if ((cla_read || cla_write) && !prev_act) grants.push_back((cla_addr == I_ADDR_T4) ? "I" : "D");
    prev_act = cla_read || cla_write;
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_adaptor();
    cla_resp  = 0;
    cla_rdata = rand_line();
    if (m_owner != NONE) begin
      if (!ad_busy) begin ad_busy = 1; ad_wait = $urandom_range(lat_hi, lat_lo); end
      if (ad_wait == 0) begin cla_resp = 1; ad_busy = 0; end
      else ad_wait--;
    end else begin
      ad_busy = 0;
      if (stray_en && $urandom_range(3, 0) == 0) cla_resp = 1;
    end
  endtask

  task automatic drive_requesters();
    int op;
    if (i_read) begin
      if (m_i_done != i_seen) begin
        i_seen = m_i_done;
        if ($urandom_range(1, 0) == 1) i_read = 0; else i_addr = rand_addr();
      end else if ($urandom_range(80, 0) == 0) i_read = 0;
    end else if ($urandom_range(2, 0) == 0) begin
      i_read = 1; i_addr = rand_addr(); i_seen = m_i_done;
    end
    if (d_read || d_write) begin
      if (m_d_done != d_seen) begin
        d_seen = m_d_done;
        if ($urandom_range(1, 0) == 1) begin d_read = 0; d_write = 0; end
        else d_addr = rand_addr();
      end else if ($urandom_range(80, 0) == 0) begin d_read = 0; d_write = 0; end
    end else if ($urandom_range(2, 0) == 0) begin
      op = $urandom_range(9, 0);
      d_read = (op <= 4); d_write = (op >= 4);
      d_addr = rand_addr(); d_wdata = rand_line(); d_seen = m_d_done;
    end
  endtask

  task automatic do_reset();
    rst = 1; i_read = 0; d_read = 0; d_write = 0; cla_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; cla_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    stray_en = 0; lat_lo = 0; lat_hi = 0;
    // Reset state.
    do_reset();
    check("rst_cla_read", cla_read, 1'b0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_timeout", arb_timeout, 1'b0);

    // Single I read, response 6 cycles after the command appears.
    i_addr = 32'h0000_1040; i_read = 1;
    sample(); check("t2_idle_no_cmd", cla_read, 1'b0); advance();
    sample(); check("t2_cla_read", cla_read, 1'b1); check("t2_cla_addr", cla_addr, 32'h0000_1040); advance();
    repeat (5) begin sample(); advance(); end
    cla_resp = 1; cla_rdata = {32{8'hA5}};
    sample();
    check("t2_i_resp", i_resp, 1'b1); check("t2_i_rdata", i_rdata, {32{8'hA5}});
    check("t2_d_resp", d_resp, 1'b0);
    advance();
    cla_resp = 0; i_read = 0; cla_rdata = '0;
    sample(); check("t2_turn_read", cla_read, 1'b0); check("t2_hold", i_rdata, {32{8'hA5}}); advance();

    // Single D writeback.
    d_addr = 32'h8000_0200; d_wdata = {4{64'h0123_4567_89AB_CDEF}}; d_write = 1;
    sample(); advance();
    repeat (4) begin
      sample();
      check("t3_cla_write", cla_write, 1'b1); check("t3_cla_read", cla_read, 1'b0);
      check("t3_wdata", cla_wdata, {4{64'h0123_4567_89AB_CDEF}});
      advance();
    end
    cla_resp = 1;
    sample(); check("t3_d_resp", d_resp, 1'b1); check("t3_i_resp", i_resp, 1'b0); advance();
    cla_resp = 0; d_write = 0;
    sample(); check("t3_d_resp_once", d_resp, 1'b0); advance();
    sample(); advance();

    // Illegal read+write (read wins), then the request drops mid-grant.
    d_addr = 32'h8000_0400; d_read = 1; d_write = 1;
    sample(); advance();
    sample(); check("t3b_read_wins", cla_read, 1'b1); check("t3b_no_write", cla_write, 1'b0); advance();
    d_read = 0; d_write = 0;
    sample(); check("t3b_drop_read", cla_read, 1'b0); check("t3b_drop_addr", cla_addr, 32'h8000_0400); advance();
    cla_resp = 1;
    sample(); check("t3b_late_resp", d_resp, 1'b1); advance();
    cla_resp = 0;

    // Stray responses in IDLE and TURN.
    sample(); advance();
    cla_resp = 1;
    sample(); check("t6_idle_iresp", i_resp, 1'b0); check("t6_idle_dresp", d_resp, 1'b0); advance();
    cla_resp = 0; i_addr = 32'h0000_2000; i_read = 1;
    sample(); check("t6_still_idle", cla_read, 1'b0); advance();
    sample(); check("t6_grant", cla_read, 1'b1); advance();
    cla_resp = 1;
    sample(); check("t6_resp", i_resp, 1'b1); advance();
    i_read = 0;
    sample(); check("t6_turn_iresp", i_resp, 1'b0); advance();
    cla_resp = 0;
    sample(); check("t6_back_idle", cla_read, 1'b0); advance();

    // Simultaneous requests held continuously.
    do_reset();
    lat_lo = 2; lat_hi = 2; grants.delete();
    i_addr = I_ADDR_T4; d_addr = D_ADDR_T4; i_read = 1; d_read = 1;
    for (int c = 0; c < 300 && (i_read || d_read); c++) begin
      sample(); advance();
      if (m_i_done >= 2) i_read = 0;
      if (m_d_done >= 3) d_read = 0;
      drive_adaptor();
    end
    repeat (3) begin sample(); advance(); drive_adaptor(); end
`ifdef CACHELINE_ARB_RR_EN
    exp_order = "DIDID";
`else
    exp_order = "DDDII";
`endif
    check("t4_grant_count", grants.size(), exp_order.len());
    for (int k = 0; k < grants.size() && k < exp_order.len(); k++)
      check($sformatf("t4_grant_%0d", k), grants[k], exp_order[k]);

    // Adaptor never responds: timeout, then reset mid-grant.
    do_reset();
    i_addr = 32'h0000_3000; i_read = 1;
    sample(); advance();
    for (int k = 1; k <= TO; k++) begin
      sample();
      if (k == TO) check("t5_not_yet", arb_timeout, 1'b0);
      advance();
    end
    sample(); check("t5_timeout", arb_timeout, 1'b1); check("t5_grant_held", cla_read, 1'b1); advance();
    sample(); advance();
    cla_resp = 1;
    #1 rst = 1;
    #1;
    check("t5_rst_iresp", i_resp, 1'b0); check("t5_rst_read", cla_read, 1'b0);
    check("t5_rst_addr", cla_addr, '0); check("t5_rst_timeout", arb_timeout, 1'b0);
    check("t5_rst_rdata", i_rdata, '0);
    do_reset();

    // Randomized traffic with random latency and stray responses.
    lat_lo = 0; lat_hi = 5; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      sample(); advance();
      drive_requesters();
      drive_adaptor();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
